// File: rtl/d5m_pkg.sv
// Shared types and constants for the D5M capture front end.
package d5m_pkg;

  localparam int unsigned PIXEL_W      = 12;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } d5m_state_e;

endpackage

// File: rtl/d5m_sync2.sv
// Two-flop level synchronizer into the D5M_PIXLCLK domain.
module d5m_sync2 (
  input  logic D5M_PIXLCLK,
  input  logic RST_N,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge D5M_PIXLCLK or negedge RST_N) begin
    if (!RST_N) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/d5m_frame_gate.sv
// Sensor input register, whole-frame capture gating and active-window crop
// feeding the three-pixel packer.
module d5m_frame_gate
  import d5m_pkg::*;
#(
  parameter int unsigned H_START     = 0,
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned V_START     = 0,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter bit          SINGLE_SHOT = 1'b1,
  parameter int unsigned CNT_W       = 12
) (
  input  logic               D5M_PIXLCLK,
  input  logic               RST_N,
  input  logic               iFVAL,
  input  logic               iLVAL,
  input  logic [PIXEL_W-1:0] iDATA,
  input  logic               iSTART,
  input  logic               iSTOP,
  output logic [PIXEL_W-1:0] oDATA,
  output logic               oDATA_VAL,
  output logic [CNT_W-1:0]   oX_CNT,
  output logic [CNT_W-1:0]   oY_CNT,
  output logic [31:0]        oFRAME_CNT,
  output logic               oFRAME_DONE,
  output logic               oBUSY
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               fval_r, lval_r, fval_d, lval_d;
  logic [PIXEL_W-1:0] data_r;
  logic               start_s, stop_s, start_d, stop_d;
  logic               fval_rise, fval_fall, lval_fall;
  logic               start_rise, stop_rise;
  logic [CNT_W-1:0]   x_cnt, y_cnt;
  logic               x_in, y_in;

  d5m_state_e state, state_n;
  logic       stop_pend, stop_pend_n;
  logic       done_n;

  d5m_sync2 u_start_sync (
    .D5M_PIXLCLK (D5M_PIXLCLK),
    .RST_N       (RST_N),
    .d           (iSTART),
    .q           (start_s)
  );

  d5m_sync2 u_stop_sync (
    .D5M_PIXLCLK (D5M_PIXLCLK),
    .RST_N       (RST_N),
    .d           (iSTOP),
    .q           (stop_s)
  );

  always_ff @(posedge D5M_PIXLCLK or negedge RST_N) begin
    if (!RST_N) begin
      fval_r  <= 1'b0;
      lval_r  <= 1'b0;
      data_r  <= '0;
      fval_d  <= 1'b0;
      lval_d  <= 1'b0;
      start_d <= 1'b0;
      stop_d  <= 1'b0;
    end else begin
      fval_r  <= iFVAL;
      lval_r  <= iLVAL;
      data_r  <= iDATA;
      fval_d  <= fval_r;
      lval_d  <= lval_r;
      start_d <= start_s;
      stop_d  <= stop_s;
    end
  end

  always_comb begin
    fval_rise  = fval_r & ~fval_d;
    fval_fall  = ~fval_r & fval_d;
    lval_fall  = ~lval_r & lval_d;
    start_rise = start_s & ~start_d;
    stop_rise  = stop_s & ~stop_d;
  end

  // x_cnt/y_cnt hold the column/line of the pixel currently in stage 1.
  always_ff @(posedge D5M_PIXLCLK or negedge RST_N) begin
    if (!RST_N) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (!lval_r)
        x_cnt <= '0;
      else if (x_cnt != CNT_MAX)
        x_cnt <= x_cnt + 1'b1;

      if (fval_rise)
        y_cnt <= '0;
      else if (lval_fall && fval_r && (y_cnt != CNT_MAX))
        y_cnt <= y_cnt + 1'b1;
    end
  end

  always_comb begin
    x_in = (32'(x_cnt) >= H_START) && (32'(x_cnt) < H_START + H_ACTIVE);
    y_in = (32'(y_cnt) >= V_START) && (32'(y_cnt) < V_START + V_ACTIVE);
  end

  always_comb begin
    state_n     = state;
    stop_pend_n = stop_pend;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        stop_pend_n = 1'b0;
        if (!stop_rise && start_rise)
          state_n = ARMED;
      end
      ARMED: begin
        if (stop_rise)
          state_n = IDLE;
        else if (fval_rise)
          state_n = CAPTURE;
      end
      CAPTURE: begin
        if (stop_rise)
          stop_pend_n = 1'b1;
        if (fval_fall) begin
          done_n      = 1'b1;
          stop_pend_n = 1'b0;
          if (stop_pend || stop_rise)
            state_n = IDLE;
          else if (SINGLE_SHOT)
            state_n = DONE;
          else
            state_n = ARMED;
        end
      end
      DONE: begin
        if (!start_s)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge D5M_PIXLCLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      stop_pend   <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oFRAME_CNT  <= '0;
    end else begin
      state       <= state_n;
      stop_pend   <= stop_pend_n;
      oFRAME_DONE <= done_n;
      if (done_n)
        oFRAME_CNT <= oFRAME_CNT + 32'd1;
    end
  end

  always_ff @(posedge D5M_PIXLCLK or negedge RST_N) begin
    if (!RST_N) begin
      oDATA     <= '0;
      oDATA_VAL <= 1'b0;
      oX_CNT    <= '0;
      oY_CNT    <= '0;
    end else begin
      oDATA     <= data_r;
      oDATA_VAL <= (state == CAPTURE) && fval_r && lval_r && x_in && y_in;
      oX_CNT    <= x_cnt;
      oY_CNT    <= y_cnt;
    end
  end

  always_comb oBUSY = (state == ARMED) || (state == CAPTURE);

endmodule

// File: tb/tb_d5m_frame_gate.sv
// Directed bench for d5m_frame_gate: two instances (single-shot crop and
// continuous narrow-counter) share one sensor stream; pixels go via scoreboards.
module tb_d5m_frame_gate;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fval, lval;
  logic [11:0] data;
  logic        start_a, stop_a, start_b, stop_b;

  logic [11:0] oDATA_a, oDATA_b;
  logic        oDATA_VAL_a, oDATA_VAL_b;
  logic [11:0] oX_CNT_a, oY_CNT_a;
  logic [3:0]  oX_CNT_b, oY_CNT_b;
  logic [31:0] oFRAME_CNT_a, oFRAME_CNT_b;
  logic        oFRAME_DONE_a, oFRAME_DONE_b;
  logic        oBUSY_a, oBUSY_b;

  typedef struct {
    logic [11:0] d;
    int          x;
    int          y;
    int          c;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int compared = 0;
  int mism     = 0;
  int cyc      = 0;
  int a_seen   = 0;
  int b_seen   = 0;
  int done_a   = 0;
  int done_b   = 0;
  int x_probe_cyc = -1;
  logic [3:0] x_probe;
  logic busy_b_s, done_b_s;
  logic bpre, bpost, dpost;

  always #5 clk = ~clk;

  d5m_frame_gate #(
    .H_START(2), .H_ACTIVE(4), .V_START(1), .V_ACTIVE(2),
    .SINGLE_SHOT(1'b1), .CNT_W(12)
  ) u_dut_a (
    .D5M_PIXLCLK(clk), .RST_N(rst_n), .iFVAL(fval), .iLVAL(lval), .iDATA(data),
    .iSTART(start_a), .iSTOP(stop_a), .oDATA(oDATA_a), .oDATA_VAL(oDATA_VAL_a),
    .oX_CNT(oX_CNT_a), .oY_CNT(oY_CNT_a), .oFRAME_CNT(oFRAME_CNT_a),
    .oFRAME_DONE(oFRAME_DONE_a), .oBUSY(oBUSY_a)
  );

  d5m_frame_gate #(
    .H_START(2), .H_ACTIVE(4), .V_START(0), .V_ACTIVE(16),
    .SINGLE_SHOT(1'b0), .CNT_W(4)
  ) u_dut_b (
    .D5M_PIXLCLK(clk), .RST_N(rst_n), .iFVAL(fval), .iLVAL(lval), .iDATA(data),
    .iSTART(start_b), .iSTOP(stop_b), .oDATA(oDATA_b), .oDATA_VAL(oDATA_VAL_b),
    .oX_CNT(oX_CNT_b), .oY_CNT(oY_CNT_b), .oFRAME_CNT(oFRAME_CNT_b),
    .oFRAME_DONE(oFRAME_DONE_b), .oBUSY(oBUSY_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    exp_t e;
    if (oDATA_VAL_a) begin
      a_seen++;
      chk("A_expected_pixel", 32'(qa.size() != 0), 1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("A_data", oDATA_a, e.d);
        chk("A_x", oX_CNT_a, e.x);
        chk("A_y", oY_CNT_a, e.y);
        chk("A_latency", cyc, e.c);
      end
    end
    if (oDATA_VAL_b) begin
      b_seen++;
      chk("B_expected_pixel", 32'(qb.size() != 0), 1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("B_data", oDATA_b, e.d);
        chk("B_x", oX_CNT_b, e.x);
        chk("B_y", oY_CNT_b, e.y);
        chk("B_latency", cyc, e.c);
      end
    end
    if (oFRAME_DONE_a) done_a++;
    if (oFRAME_DONE_b) done_b++;
    if (cyc == x_probe_cyc) x_probe = oX_CNT_b;
    busy_b_s = oBUSY_b;
    done_b_s = oFRAME_DONE_b;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // evt: 1 = raise start_a, 2 = raise stop_b, 3 = pulse reset, at start of evt_line
  task automatic frame(input int nl, input int np, input bit ea, input bit eb,
                       input int evt_line, input int evt);
    bit live;
    tick(); fval = 1'b1; lval = 1'b0;
    tick(); tick();
    for (int l = 0; l < nl; l++) begin
      if (l == evt_line) begin
        case (evt)
          1: start_a = 1'b1;
          2: stop_b  = 1'b1;
          3: begin
            rst_n = 1'b0;
            #1;
            chk("rst_val_b", oDATA_VAL_b, 0);
            chk("rst_fcnt_b", oFRAME_CNT_b, 0);
            chk("rst_busy_b", oBUSY_b, 0);
            chk("rst_y_b", oY_CNT_b, 0);
            chk("rst_data_a", oDATA_a, 0);
          end
          default: ;
        endcase
      end
      live = !(evt == 3 && l >= evt_line);
      for (int c = 0; c < np; c++) begin
        tick();
        if (evt == 3 && l == evt_line && c == 2) rst_n = 1'b1;
        lval = 1'b1;
        data = 12'(l * 16 + c);
        x_probe_cyc = cyc + 2;
        if (ea && live && c >= 2 && c < 6 && l >= 1 && l < 3)
          qa.push_back('{12'(l * 16 + c), c, l, cyc + 2});
        if (eb && live && c >= 2 && c < 6 && l < 16)
          qb.push_back('{12'(l * 16 + c), (c > 15) ? 15 : c, l, cyc + 2});
      end
      tick(); lval = 1'b0;
      tick(); tick();
    end
    tick(); fval = 1'b0;
    tick(); tick();
    bpre = busy_b_s;
    tick();
    bpost = busy_b_s;
    dpost = done_b_s;
    idle(4);
  endtask

  initial begin
    rst_n = 1'b0; fval = 1'b0; lval = 1'b0; data = '0;
    start_a = 1'b0; stop_a = 1'b0; start_b = 1'b0; stop_b = 1'b0;
    idle(3);
    rst_n = 1'b1;
    tick();
    chk("reset_val_a", oDATA_VAL_a, 0);
    chk("reset_data_a", oDATA_a, 0);
    chk("reset_x_a", oX_CNT_a, 0);
    chk("reset_y_a", oY_CNT_a, 0);
    chk("reset_fcnt_a", oFRAME_CNT_a, 0);
    chk("reset_done_a", oFRAME_DONE_a, 0);
    chk("reset_busy_a", oBUSY_a, 0);
    chk("reset_busy_b", oBUSY_b, 0);

    // basic crop, single shot
    start_a = 1'b1;
    idle(8);
    chk("armed_busy_a", oBUSY_a, 1);
    frame(4, 8, 1, 0, -1, 0);
    chk("crop_queue_a", qa.size(), 0);
    chk("crop_count_a", a_seen, 8);
    chk("crop_fcnt_a", oFRAME_CNT_a, 1);
    chk("crop_done_a", done_a, 1);
    chk("done_not_busy_a", oBUSY_a, 0);

    // start held: no re-capture until it falls
    frame(4, 8, 0, 0, -1, 0);
    frame(4, 8, 0, 0, -1, 0);
    chk("held_fcnt_a", oFRAME_CNT_a, 1);
    chk("held_count_a", a_seen, 8);
    start_a = 1'b0;
    idle(6);
    start_a = 1'b1;
    idle(8);
    frame(4, 8, 1, 0, -1, 0);
    chk("rearm_count_a", a_seen, 16);
    chk("rearm_fcnt_a", oFRAME_CNT_a, 2);
    start_a = 1'b0;
    idle(6);

    // arm mid-frame: that frame skipped, next one whole
    frame(4, 8, 0, 0, 1, 1);
    chk("midarm_skip_a", a_seen, 16);
    frame(4, 8, 1, 0, -1, 0);
    chk("midarm_count_a", a_seen, 24);
    chk("midarm_fcnt_a", oFRAME_CNT_a, 3);
    start_a = 1'b0;
    idle(6);

    // continuous with stop during frame 2
    start_b = 1'b1;
    idle(8);
    frame(4, 8, 0, 1, -1, 0);
    frame(4, 8, 0, 1, 2, 2);
    chk("stop_busy_pre_b", bpre, 1);
    chk("stop_busy_post_b", bpost, 0);
    chk("stop_done_b", dpost, 1);
    chk("stop_fcnt_b", oFRAME_CNT_b, 2);
    chk("stop_count_b", b_seen, 32);
    frame(4, 8, 0, 0, -1, 0);
    chk("after_stop_count_b", b_seen, 32);
    chk("after_stop_fcnt_b", oFRAME_CNT_b, 2);
    stop_b = 1'b0; start_b = 1'b0;
    idle(6);

    // X saturation on a 4-bit counter
    start_b = 1'b1;
    idle(8);
    frame(2, 20, 0, 1, -1, 0);
    chk("sat_x_b", x_probe, 15);
    chk("sat_count_b", b_seen, 40);

    // short lines: only column 2 lands in the window
    start_a = 1'b1;
    idle(8);
    frame(3, 3, 1, 1, -1, 0);
    chk("short_count_a", a_seen, 26);
    chk("short_count_b", b_seen, 43);
    chk("short_x_b", x_probe, 2);

    // FVAL pulse without lines still counts
    frame(0, 0, 0, 0, -1, 0);
    chk("glitch_fcnt_b", oFRAME_CNT_b, 5);
    chk("glitch_done_b", done_b, 5);
    chk("glitch_fcnt_a", oFRAME_CNT_a, 4);
    start_a = 1'b0; start_b = 1'b0;
    idle(6);

    // reset in the middle of a captured frame
    frame(4, 8, 0, 1, 2, 3);
    chk("rst_count_b", b_seen, 51);
    chk("rst_nodone_b", done_b, 5);
    frame(4, 8, 0, 0, -1, 0);
    chk("rst_idle_count_b", b_seen, 51);
    chk("rst_idle_fcnt_b", oFRAME_CNT_b, 0);
    start_b = 1'b1;
    idle(8);
    frame(4, 8, 0, 1, -1, 0);
    chk("rst_rearm_count_b", b_seen, 67);
    chk("rst_rearm_fcnt_b", oFRAME_CNT_b, 1);

    idle(10);
    chk("final_queue_a", qa.size(), 0);
    chk("final_queue_b", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule

// File: doc/d5m_frame_gate.md
Name: d5m_frame_gate

Overview:
- Upstream capture stage between the D5M sensor pins and the three-pixel packer/FIFO writer.
- Registers raw FVAL/LVAL/DATA from the sensor and aligns capture to whole-frame boundaries.
- Crops each frame to a programmable active window and emits the 12-bit pixel stream plus a pixel-valid strobe (oDATA/oDATA_VAL), which the packer consumes as iDATA/iDATA_VAL.
- Provides X/Y/frame counters and a frame-done pulse so the packer's word counter can be cross-checked.

Parameters:
- H_START, 0: first captured column (pixel index within LVAL-high run).
- H_ACTIVE, 640: number of captured columns per line.
- V_START, 0: first captured line (line index within FVAL-high run).
- V_ACTIVE, 480: number of captured lines per frame.
- SINGLE_SHOT, 1: 1 = capture exactly one frame per start request; 0 = continuous until stop.
- CNT_W, 12: width of the X/Y counters.

Ports:
- D5M_PIXLCLK  in  1  sensor pixel clock; all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- iFVAL  in  1  sensor frame valid.
- iLVAL  in  1  sensor line valid.
- iDATA  in  12  sensor pixel data.
- iSTART  in  1  capture request, level, asynchronous to D5M_PIXLCLK.
- iSTOP  in  1  stop request, level, asynchronous to D5M_PIXLCLK.
- oDATA  out  12  cropped pixel data.
- oDATA_VAL  out  1  oDATA holds a valid in-window pixel this cycle.
- oX_CNT  out  CNT_W  column index of the current pixel within the line.
- oY_CNT  out  CNT_W  line index within the frame.
- oFRAME_CNT  out  32  count of completed captured frames.
- oFRAME_DONE  out  1  one-cycle pulse at the end of each captured frame.
- oBUSY  out  1  high in ARMED or CAPTURE.

Behaviour:
- **Reset values.** All outputs 0 and state IDLE. Internal input registers and synchronizers are cleared.
- **Input and sync stages.**
  - iFVAL, iLVAL and iDATA are registered once (stage 1).
  - iSTART and iSTOP each pass through a 2-flop synchronizer. Only their rising edges act, detected from the synchronized level.
- **Edge detects.** All edges are taken on the stage-1 signals:
  - fval_rise, fval_fall from FVAL.
  - lval_fall from LVAL.
- **Counters.**
  - X: cleared on lval_fall and while LVAL is low. Increments each cycle LVAL is high. Saturates at all-ones, with no wrap.
  - Y: cleared on fval_rise. Increments on each lval_fall while FVAL is high. Saturates at all-ones.
- **State machine.**
  - IDLE: on start_rise go to ARMED.
  - ARMED: wait for fval_rise, then go to CAPTURE. A frame already in progress is skipped. stop_rise returns to IDLE.
  - CAPTURE: pixels are emitted. On fval_fall, pulse oFRAME_DONE and increment oFRAME_CNT (wraps modulo 2^32). The next state is then chosen in this priority order:
    - IDLE if stop was latched.
    - DONE if SINGLE_SHOT = 1.
    - ARMED otherwise.
  - stop_rise during CAPTURE is latched and takes effect only at fval_fall; the frame is never truncated.
  - DONE: hold until the synchronized iSTART is low, then go to IDLE. This stops a held-high start from causing a re-capture.
- **Simultaneous events.** start_rise and stop_rise in the same cycle in IDLE: stop wins and the state stays IDLE.
- **Output stage.** oDATA_VAL is registered as stage 2 and is high only when all of the following hold:
  - state is CAPTURE;
  - stage-1 FVAL and LVAL are both high;
  - H_START ≤ X < H_START+H_ACTIVE;
  - V_START ≤ Y < V_START+V_ACTIVE.
- **Data, counter outputs and latency.**
  - oDATA is registered together with oDATA_VAL and updates every cycle, whether or not the pixel is valid.
  - oX_CNT and oY_CNT are the stage-2 registered copies.
  - Latency from iDATA/iLVAL to oDATA/oDATA_VAL is 2 cycles.
- **Short frames and lines.** If the sensor delivers fewer lines or columns than the window, fewer valid pixels are emitted; no padding is inserted.
- **Mid-frame reset.** On release, the block is in IDLE and needs a fresh start_rise followed by an fval_rise. No partial frame is ever emitted.
- **Glitch.** An FVAL high pulse that contains no LVAL still counts as a frame and produces oFRAME_DONE; oFRAME_CNT increments.

Decomposition:
- Package d5m_pkg:
  - state typedef {IDLE, ARMED, CAPTURE, DONE};
  - PIXEL_W = 12;
  - default frame geometry constants 640/480.
- Sub-module d5m_sync2: 2-flop synchronizer, instantiated twice (start and stop).

Test Plan:
- **Basic crop.** Frame of 4 lines × 8 pixels (iDATA = line*16 + col), with H_START = 2, H_ACTIVE = 4, V_START = 1, V_ACTIVE = 2, start pulse → exactly 8 oDATA_VAL pulses with data 0x12..0x15 then 0x22..0x25, each 2 cycles after its input; one oFRAME_DONE; oFRAME_CNT = 1.
- **Mid-frame arm.** Start asserted while FVAL is high → no valid pixels for that frame; the next whole frame is captured in full (640×480 = 307,200 valid pixels with default parameters).
- **Single-shot.** SINGLE_SHOT = 1, start held high across 3 frames → only 1 frame captured; state reaches DONE and goes to IDLE only after start falls.
- **Continuous with stop.** SINGLE_SHOT = 0, stop raised mid-way through frame 2 → frame 2 completes in full; oFRAME_CNT = 2; no frame-3 pixels; oBUSY drops the cycle after fval_fall.
- **Reset mid-frame.** RST_N low during line 100 → all outputs 0 immediately; after release, no oDATA_VAL until a new start plus fval_rise.
- **Short-line boundary.** Lines of 3 pixels with H_START = 2, H_ACTIVE = 4 → 1 valid pixel per line (col 2 only); counter saturation check with CNT_W = 4 and a 20-pixel line → X holds at 15.
